// File: rtl/alu_pkg.sv
// Shared types and helpers for the digit-serial ALU.
package alu_pkg;

   typedef enum logic [1:0] {
      ALU_XOR  = 2'b00,
      ALU_XNOR = 2'b01,
      ALU_ADD  = 2'b10,
      ALU_SUB  = 2'b11
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } alu_state_e;

   // Number of digit passes needed to cover one operand.
   function automatic int unsigned alu_num_digits(input int unsigned width,
                                                  input int unsigned digit);
      return width / digit;
   endfunction

endpackage

// File: rtl/alu_serial_if.sv
// Operand/result valid-ready bundle between issuing controller, alu_serial and consumer.
interface alu_serial_if #(
   parameter int unsigned WIDTH = 64
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic [1:0]       op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] s;
   logic             cout;

   // Controller/consumer side.
   modport master (
      output in_valid, a, b, cin, op, out_ready,
      input  in_ready, out_valid, s, cout
   );

   // ALU side.
   modport slave (
      input  in_valid, a, b, cin, op, out_ready,
      output in_ready, out_valid, s, cout
   );
endinterface

// File: rtl/alu_digit.sv
// One DIGIT-wide slice of the ALU; purely combinational, carry chain DIGIT bits deep.
module alu_digit
   import alu_pkg::*;
#(
   parameter int unsigned DIGIT = 8
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             cin,
   input  alu_op_e          op,
   output logic [DIGIT-1:0] s,
   output logic             cout
);

   logic [DIGIT:0] sum;

   // Decode the operation; logic ops never produce a carry.
   always_comb begin
      sum  = '0;
      s    = '0;
      cout = 1'b0;
      unique case (op)
         ALU_XOR:  s = a ^ b;
         ALU_XNOR: s = ~(a ^ b);
         ALU_ADD: begin
            sum  = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};
            s    = sum[DIGIT-1:0];
            cout = sum[DIGIT];
         end
         ALU_SUB: begin
            sum  = {1'b0, a} + {1'b0, ~b} + {{DIGIT{1'b0}}, cin};
            s    = sum[DIGIT-1:0];
            cout = sum[DIGIT];
         end
      endcase
   end

endmodule

// File: rtl/alu_serial.sv
// Digit-serial xor/xnor/add/sub ALU: DIGIT bits per clock, LSB digit first,
// valid/ready on both sides. Result registers change only when a pass completes.
module alu_serial
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DIGIT = 8
) (
   input logic         clk,
   input logic         rst,
   alu_serial_if.slave bus
);

   localparam int unsigned NumDigits = alu_num_digits(WIDTH, DIGIT);
   localparam int unsigned CntW      = (NumDigits > 1) ? $clog2(NumDigits) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(NumDigits - 1);

   if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
      $error("alu_serial: WIDTH must be a multiple of DIGIT");
   end

   alu_state_e       state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   alu_op_e          op_q, op_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic             cout_q, cout_d;

   logic [31:0]      digit_base;
   logic [DIGIT-1:0] dig_a, dig_b, dig_s;
   logic             dig_cout;

   assign digit_base = 32'(cnt_q) * DIGIT;
   assign dig_a      = a_q[digit_base +: DIGIT];
   assign dig_b      = b_q[digit_base +: DIGIT];

   alu_digit #(
      .DIGIT(DIGIT)
   ) u_digit (
      .a   (dig_a),
      .b   (dig_b),
      .cin (carry_q),
      .op  (op_q),
      .s   (dig_s),
      .cout(dig_cout)
   );

   // Next-state: capture in IDLE, one digit per cycle in BUSY, wait for consumer in DONE.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      acc_d   = acc_q;
      s_d     = s_q;
      cout_d  = cout_q;
      unique case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               a_d     = bus.a;
               b_d     = bus.b;
               op_d    = alu_op_e'(bus.op);
               carry_d = bus.cin;
               cnt_d   = '0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            acc_d[digit_base +: DIGIT] = dig_s;
            carry_d = dig_cout;
            if (cnt_q == LastCnt) begin
               // Publish the full result including the digit computed this cycle.
               state_d = DONE;
               cnt_d   = '0;
               s_d     = acc_d;
               cout_d  = ((op_q == ALU_ADD) || (op_q == ALU_SUB)) ? dig_cout : 1'b0;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // All state; reset aborts any pass and clears the visible result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= ALU_XOR;
         acc_q   <= '0;
         s_q     <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         acc_q   <= acc_d;
         s_q     <= s_d;
         cout_q  <= cout_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.s         = s_q;
   assign bus.cout      = cout_q;

endmodule

// File: tb/tb_alu_serial.sv
// Directed bench for alu_serial: 8-bit-digit instance plus a single-digit instance.
module tb_alu_serial;
   import alu_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   alu_serial_if #(.WIDTH(64)) bus0 ();
   alu_serial_if #(.WIDTH(64)) bus1 ();

   alu_serial #(.WIDTH(64), .DIGIT(8)) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(bus0)
   );

   alu_serial #(.WIDTH(64), .DIGIT(64)) u_dut_one (
      .clk(clk),
      .rst(rst),
      .bus(bus1)
   );

   typedef struct {
      logic [63:0] a;
      logic [63:0] b;
      logic        cin;
      logic [1:0]  op;
      logic [63:0] s;
      logic        cout;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
      end
   endtask

   // Issue one op on bus0 and count cycles from acceptance to out_valid.
   task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic c,
                         input logic [1:0] o, output int lat);
      int guard;
      @(negedge clk);
      guard = 0;
      while (!bus0.in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      bus0.a        = a;
      bus0.b        = b;
      bus0.cin      = c;
      bus0.op       = o;
      bus0.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus0.in_valid = 1'b0;
      lat = 0;
      while (!bus0.out_valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic take_result();
      @(negedge clk);
      bus0.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus0.out_ready = 1'b0;
   endtask

   initial begin
      int lat;

      vecs[0] = '{64'h00000000FFFFFFFF, 64'h0000FFFF0000FFFF, 1'b1, 2'b00, 64'h0000FFFFFFFF0000, 1'b0};
      vecs[1] = '{64'h00000000FFFFFFFF, 64'h0000FFFF0000FFFF, 1'b1, 2'b01, 64'hFFFF00000000FFFF, 1'b0};
      vecs[2] = '{64'h5555555555555555, 64'hAAAAAAAAAAAAAAAA, 1'b0, 2'b10, 64'hFFFFFFFFFFFFFFFF, 1'b0};
      vecs[3] = '{64'h5555555555555555, 64'hAAAAAAAAAAAAAAAA, 1'b1, 2'b10, 64'h0000000000000000, 1'b1};
      vecs[4] = '{64'h000000000000000F, 64'h0000000000000009, 1'b1, 2'b11, 64'h0000000000000006, 1'b1};
      vecs[5] = '{64'h000000000000000F, 64'h0000000000000009, 1'b0, 2'b11, 64'h0000000000000005, 1'b1};
      vecs[6] = '{64'h0000000000000001, 64'h000000000000000B, 1'b1, 2'b11, 64'hFFFFFFFFFFFFFFF6, 1'b0};
      vecs[7] = '{64'h0123456789ABCDEF, 64'h1111111111111111, 1'b0, 2'b10, 64'h123456789ABCDF00, 1'b0};

      // Reset with in_valid asserted: must be ignored.
      rst            = 1'b1;
      bus0.in_valid  = 1'b1;
      bus0.a         = 64'h1234;
      bus0.b         = 64'h5678;
      bus0.cin       = 1'b1;
      bus0.op        = 2'b10;
      bus0.out_ready = 1'b0;
      bus1.in_valid  = 1'b1;
      bus1.a         = '0;
      bus1.b         = '0;
      bus1.cin       = 1'b0;
      bus1.op        = 2'b00;
      bus1.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", bus0.in_ready, 1'b1);
      check("rst_out_valid", bus0.out_valid, 1'b0);
      check("rst_s", bus0.s, 64'h0);
      check("rst_cout", bus0.cout, 1'b0);
      check("rst1_out_valid", bus1.out_valid, 1'b0);
      bus0.in_valid = 1'b0;
      bus1.in_valid = 1'b0;
      rst           = 1'b0;

      // Directed vectors.
      for (int i = 0; i < 8; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].op, lat);
         check($sformatf("vec%0d_latency", i), 64'(lat), 64'd8);
         check($sformatf("vec%0d_s", i), bus0.s, vecs[i].s);
         check($sformatf("vec%0d_cout", i), bus0.cout, vecs[i].cout);
         check($sformatf("vec%0d_in_ready_done", i), bus0.in_ready, 1'b0);
         take_result();
         check($sformatf("vec%0d_in_ready_after", i), bus0.in_ready, 1'b1);
      end

      // Backpressure: result held while out_ready low, inputs ignored.
      run_op(64'hF, 64'h9, 1'b1, 2'b11, lat);
      check("bp_latency", 64'(lat), 64'd8);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         bus0.a        = 64'hDEAD_0000 + 64'(i);
         bus0.b        = 64'hBEEF_0000 - 64'(i);
         bus0.op       = 2'b00;
         bus0.in_valid = 1'b1;
         @(posedge clk);
         #1;
         check($sformatf("bp%0d_s", i), bus0.s, 64'h6);
         check($sformatf("bp%0d_cout", i), bus0.cout, 1'b1);
         check($sformatf("bp%0d_in_ready", i), bus0.in_ready, 1'b0);
         check($sformatf("bp%0d_out_valid", i), bus0.out_valid, 1'b1);
      end
      // Handshake edge: in_valid still high but only the following edge may accept.
      @(negedge clk);
      bus0.a         = 64'h00FF00FF00FF00FF;
      bus0.b         = 64'h0F0F0F0F0F0F0F0F;
      bus0.op        = 2'b00;
      bus0.cin       = 1'b0;
      bus0.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus0.out_ready = 1'b0;
      check("hs_out_valid", bus0.out_valid, 1'b0);
      check("hs_in_ready", bus0.in_ready, 1'b1);
      check("hs_s_held", bus0.s, 64'h6);
      @(posedge clk);
      #1;
      bus0.in_valid = 1'b0;
      check("hs_accepted", bus0.in_ready, 1'b0);
      lat = 0;
      while (!bus0.out_valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("hs_latency", 64'(lat), 64'd8);
      check("hs_s", bus0.s, 64'h0FF00FF00FF00FF0);
      take_result();

      // Reset in the middle of a pass.
      @(negedge clk);
      bus0.a        = 64'h0123456789ABCDEF;
      bus0.b        = 64'h1111111111111111;
      bus0.cin      = 1'b0;
      bus0.op       = 2'b10;
      bus0.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus0.in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("midrst_out_valid", bus0.out_valid, 1'b0);
      check("midrst_s", bus0.s, 64'h0);
      check("midrst_cout", bus0.cout, 1'b0);
      check("midrst_in_ready", bus0.in_ready, 1'b1);
      @(negedge clk);
      rst = 1'b0;
      run_op(64'h0123456789ABCDEF, 64'h1111111111111111, 1'b0, 2'b10, lat);
      check("postrst_latency", 64'(lat), 64'd8);
      check("postrst_s", bus0.s, 64'h123456789ABCDF00);
      check("postrst_cout", bus0.cout, 1'b0);
      take_result();

      // Single-digit instance: result one cycle after acceptance.
      @(negedge clk);
      bus1.a        = 64'h5555555555555555;
      bus1.b        = 64'hAAAAAAAAAAAAAAAA;
      bus1.cin      = 1'b1;
      bus1.op       = 2'b10;
      bus1.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus1.in_valid = 1'b0;
      check("one_busy", bus1.out_valid, 1'b0);
      @(posedge clk);
      #1;
      check("one_out_valid", bus1.out_valid, 1'b1);
      check("one_s", bus1.s, 64'h0);
      check("one_cout", bus1.cout, 1'b1);
      @(negedge clk);
      bus1.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus1.out_ready = 1'b0;
      check("one_in_ready", bus1.in_ready, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
